alarm_sequencer: RTL and testbench
==================================

Name: alarm_sequencer

Overview:
Alarm-event controller for the alarm clock top level. Compares running time against the stored alarm time and sequences ring, snooze and stop behaviour. Drives the alarm LED blink and reports snooze status to the display and LED logic. Runs on the system clock and advances its timers only on the single-cycle 1 Hz tick from the clock divider.

Parameters:
SNOOZE_MIN, 5, snooze length in minutes (1..15)
RING_TIMEOUT_S, 60, seconds of unanswered ringing before auto-stop (1..255)
MAX_SNOOZE, 3, maximum snoozes per alarm event (1..7)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
tick_1hz  in  1  one-clk pulse per second
cur_hours  in  5  current hours, 0..23
cur_minutes  in  6  current minutes, 0..59
alarm_hours  in  5  stored alarm hours
alarm_minutes  in  6  stored alarm minutes
armed  in  1  alarm enabled
adjust_mode  in  1  1 while the user is adjusting time or alarm; suppresses new triggers
snooze_btn  in  1  debounced one-clk pulse
stop_btn  in  1  debounced one-clk pulse
ringing  out  1  1 in RING state
alarm_led  out  1  blink output: toggles on every tick_1hz while in RING, 0 otherwise
snooze_active  out  1  1 in SNOOZE state
snooze_cnt  out  3  snoozes used in the current event
missed  out  1  sticky: set on ring timeout

Behaviour:
- Reset: state=IDLE; ringing=0; alarm_led=0; snooze_active=0; snooze_cnt=0; missed=0; fired=0; all timers=0.
- Match signal: match = (cur_hours==alarm_hours) && (cur_minutes==alarm_minutes). Purely combinational.
- fired flag:
  - Set when a trigger occurs.
  - Cleared on the first clk where match=0.
  - Guarantees one trigger per matching minute.
- States: IDLE, RING, SNOOZE. All transitions are registered; outputs reflect the new state one clk after the causing event.
- IDLE:
  - Transition to RING when armed && !adjust_mode && match && !fired.
  - On that transition: set fired, clear missed, set snooze_cnt=0, ring_sec=0, alarm_led=1.
- RING:
  - Each tick_1hz: ring_sec+=1 and alarm_led toggles.
  - stop_btn → IDLE; snooze_cnt=0.
  - snooze_btn with snooze_cnt<MAX_SNOOZE → SNOOZE; snooze_cnt+=1; snooze_sec=SNOOZE_MIN*60 (10-bit).
  - snooze_btn with snooze_cnt==MAX_SNOOZE is ignored; stays in RING.
  - When ring_sec reaches RING_TIMEOUT_S (evaluated on the tick that makes it equal) → IDLE; missed=1.
- SNOOZE:
  - Each tick_1hz: snooze_sec-=1.
  - On the tick where snooze_sec becomes 0 → RING; ring_sec=0; alarm_led=1.
  - stop_btn → IDLE; snooze_cnt=0.
  - snooze_btn is ignored.
- Any state, armed=0 → IDLE next clk. snooze_cnt cleared; missed retained.
- Priority within one clk: rst > !armed > stop_btn > snooze_btn > timer expiry > tick counting. A button in the same clk as a tick wins; that tick is not counted.
- alarm_hours or alarm_minutes changing during RING or SNOOZE has no effect on the current event.
- adjust_mode only blocks new triggers from IDLE; it does not stop an active event.
- missed clears on stop_btn (in any state), on the next trigger, or on rst.
- Outputs are registered. ringing and snooze_active are never both 1.

Optional Feature:
ALARM_AUTO_SNOOZE_EN
- Defined: a RING timeout with snooze_cnt<MAX_SNOOZE auto-enters SNOOZE (snooze_cnt+=1, missed unchanged). Only a timeout with snooze_cnt==MAX_SNOOZE goes to IDLE and sets missed.
- Undefined: every RING timeout goes to IDLE and sets missed, as specified above.

Test Plan:
- Params SNOOZE_MIN=1, RING_TIMEOUT_S=5, MAX_SNOOZE=2. Set alarm 07:30, armed=1; drive time 07:29→07:30 → ringing=1 one clk later; alarm_led toggles on each tick; no retrigger while 07:30 is held after stop_btn.
- Ring, then snooze_btn → snooze_active=1, snooze_cnt=1. After 60 ticks → ringing=1. snooze_btn → snooze_cnt=2. After 60 ticks, ringing again; snooze_btn → ignored, still ringing, snooze_cnt=2.
- Ring with no buttons for 5 ticks → IDLE, missed=1. Next stop_btn → missed=0.
- snooze_btn and stop_btn in the same clk while ringing → IDLE, snooze_cnt=0. stop_btn coincident with a tick in SNOOZE → IDLE.
- armed=0 mid-SNOOZE → IDLE next clk. adjust_mode=1 at the 07:30 match → no ring. rst asserted mid-RING → all outputs 0 on the following clk.
- With ALARM_AUTO_SNOOZE_EN defined: two unanswered rings each auto-snooze (snooze_cnt 1, 2). The third timeout → IDLE, missed=1.

Source files
------------

// File: rtl/alarm_sequencer.sv
// alarm_sequencer: alarm trigger, ring/snooze/stop sequencing; `ifdef ALARM_AUTO_SNOOZE_EN makes unanswered rings auto-snooze.
module alarm_sequencer #(
  parameter int SNOOZE_MIN     = 5,
  parameter int RING_TIMEOUT_S = 60,
  parameter int MAX_SNOOZE     = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic [4:0] cur_hours,
  input  logic [5:0] cur_minutes,
  input  logic [4:0] alarm_hours,
  input  logic [5:0] alarm_minutes,
  input  logic       armed,
  input  logic       adjust_mode,
  input  logic       snooze_btn,
  input  logic       stop_btn,
  output logic       ringing,
  output logic       alarm_led,
  output logic       snooze_active,
  output logic [2:0] snooze_cnt,
  output logic       missed
);
  typedef enum logic [1:0] {IDLE, RING, SNOOZE} state_t;
  localparam logic [9:0] SNZ  = 10'(SNOOZE_MIN * 60);
  localparam logic [7:0] TMO  = 8'(RING_TIMEOUT_S);
  localparam logic [2:0] MAXS = 3'(MAX_SNOOZE);
  state_t state, state_n;
  logic led_n, missed_n, fired, fired_n, match;
  logic [2:0] cnt_n;
  logic [7:0] ring_sec, ring_n;
  logic [9:0] snz_sec, snz_n;
  assign match = (cur_hours == alarm_hours) && (cur_minutes == alarm_minutes);
  assign ringing = state == RING;
  assign snooze_active = state == SNOOZE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      alarm_led  <= 1'b0;
      snooze_cnt <= 3'd0;
      missed     <= 1'b0;
      fired      <= 1'b0;
      ring_sec   <= 8'd0;
      snz_sec    <= 10'd0;
    end else begin
      state      <= state_n;
      alarm_led  <= led_n;
      snooze_cnt <= cnt_n;
      missed     <= missed_n;
      fired      <= fired_n;
      ring_sec   <= ring_n;
      snz_sec    <= snz_n;
    end
  end
  // fired holds off retriggering until the matching minute has passed
  always_comb begin
    state_n  = state;
    led_n    = alarm_led;
    cnt_n    = snooze_cnt;
    missed_n = missed;
    fired_n  = fired & match;
    ring_n   = ring_sec;
    snz_n    = snz_sec;
    if (!armed) begin
      state_n = IDLE;
      led_n   = 1'b0;
      cnt_n   = 3'd0;
    end else if (stop_btn) begin
      state_n  = IDLE;
      led_n    = 1'b0;
      cnt_n    = 3'd0;
      missed_n = 1'b0;
    end else begin
      case (state)
        IDLE: if (!adjust_mode && match && !fired) begin
          state_n  = RING;
          fired_n  = 1'b1;
          missed_n = 1'b0;
          cnt_n    = 3'd0;
          ring_n   = 8'd0;
          led_n    = 1'b1;
        end
        RING: if (snooze_btn && snooze_cnt < MAXS) begin
          state_n = SNOOZE;
          cnt_n   = snooze_cnt + 3'd1;
          snz_n   = SNZ;
          led_n   = 1'b0;
        end else if (tick_1hz) begin
          ring_n = ring_sec + 8'd1;
          led_n  = !alarm_led;
          if (ring_sec + 8'd1 == TMO) begin
            led_n = 1'b0;
`ifdef ALARM_AUTO_SNOOZE_EN
            if (snooze_cnt < MAXS) begin
              state_n = SNOOZE;
              cnt_n   = snooze_cnt + 3'd1;
              snz_n   = SNZ;
            end else begin
              state_n  = IDLE;
              missed_n = 1'b1;
            end
`else
            state_n  = IDLE;
            missed_n = 1'b1;
`endif
          end
        end
        SNOOZE: if (tick_1hz) begin
          snz_n = snz_sec - 10'd1;
          if (snz_sec == 10'd1) begin
            state_n = RING;
            ring_n  = 8'd0;
            led_n   = 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alarm_sequencer.sv
// tb_alarm_sequencer: directed checks of alarm_sequencer with SNOOZE_MIN=1, RING_TIMEOUT_S=5, MAX_SNOOZE=2.
module tb_alarm_sequencer;
  logic clk = 1'b0, rst = 1'b1, tick_1hz = 1'b0, armed = 1'b0, adjust_mode = 1'b0;
  logic snooze_btn = 1'b0, stop_btn = 1'b0;
  logic [4:0] cur_hours = 5'd7, alarm_hours = 5'd7;
  logic [5:0] cur_minutes = 6'd29, alarm_minutes = 6'd30;
  logic ringing, alarm_led, snooze_active, missed;
  logic [2:0] snooze_cnt;
  int passed = 0, total = 0;
  alarm_sequencer #(.SNOOZE_MIN(1), .RING_TIMEOUT_S(5), .MAX_SNOOZE(2)) dut (
    .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .cur_hours(cur_hours), .cur_minutes(cur_minutes),
    .alarm_hours(alarm_hours), .alarm_minutes(alarm_minutes), .armed(armed), .adjust_mode(adjust_mode),
    .snooze_btn(snooze_btn), .stop_btn(stop_btn), .ringing(ringing), .alarm_led(alarm_led),
    .snooze_active(snooze_active), .snooze_cnt(snooze_cnt), .missed(missed)
  );
  always #5 clk = ~clk;
  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic ticks(input int n);
    repeat (n) begin
      tick_1hz = 1'b1;
      cyc();
      tick_1hz = 1'b0;
    end
  endtask
  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask
  task automatic trigger();
    cur_minutes = 6'd31;
    cyc();
    cur_minutes = 6'd30;
    cyc();
  endtask
  task automatic press_snooze();
    snooze_btn = 1'b1;
    cyc();
    snooze_btn = 1'b0;
  endtask
  task automatic press_stop();
    stop_btn = 1'b1;
    cyc();
    stop_btn = 1'b0;
  endtask
  initial begin
    cyc(2);
    chk("rst_ringing", ringing, 0);
    chk("rst_led", alarm_led, 0);
    chk("rst_snooze", snooze_active, 0);
    chk("rst_cnt", snooze_cnt, 0);
    chk("rst_missed", missed, 0);
    rst = 1'b0;
    armed = 1'b1;
    cyc();
    chk("no_match_idle", ringing, 0);
    cur_minutes = 6'd30;
    cyc();
    chk("match_ringing", ringing, 1);
    chk("match_led", alarm_led, 1);
    ticks(1);
    chk("led_tick1", alarm_led, 0);
    ticks(1);
    chk("led_tick2", alarm_led, 1);
    press_stop();
    chk("stop_idle", ringing, 0);
    chk("stop_led", alarm_led, 0);
    cyc(5);
    chk("no_retrigger", ringing, 0);
    trigger();
    chk("retrigger", ringing, 1);
    press_snooze();
    chk("snz1_active", snooze_active, 1);
    chk("snz1_not_ringing", ringing, 0);
    chk("snz1_cnt", snooze_cnt, 1);
    ticks(59);
    chk("snz_59", snooze_active, 1);
    ticks(1);
    chk("snz_expire_ring", ringing, 1);
    chk("snz_expire_led", alarm_led, 1);
    press_snooze();
    chk("snz2_cnt", snooze_cnt, 2);
    ticks(60);
    chk("snz2_expire_ring", ringing, 1);
    press_snooze();
    chk("snz_max_ring", ringing, 1);
    chk("snz_max_active", snooze_active, 0);
    chk("snz_max_cnt", snooze_cnt, 2);
    ticks(4);
    chk("tmo_4_ring", ringing, 1);
    chk("tmo_4_led", alarm_led, 1);
    ticks(1);
    chk("tmo_idle", ringing, 0);
    chk("tmo_missed", missed, 1);
    chk("tmo_led", alarm_led, 0);
    press_stop();
    chk("stop_clears_missed", missed, 0);
    trigger();
    chk("both_btn_pre", ringing, 1);
    snooze_btn = 1'b1;
    stop_btn = 1'b1;
    cyc();
    snooze_btn = 1'b0;
    stop_btn = 1'b0;
    chk("both_btn_ring", ringing, 0);
    chk("both_btn_snz", snooze_active, 0);
    chk("both_btn_cnt", snooze_cnt, 0);
    trigger();
    press_snooze();
    chk("stop_tick_pre", snooze_active, 1);
    stop_btn = 1'b1;
    tick_1hz = 1'b1;
    cyc();
    stop_btn = 1'b0;
    tick_1hz = 1'b0;
    chk("stop_tick_snz", snooze_active, 0);
    chk("stop_tick_ring", ringing, 0);
    chk("stop_tick_cnt", snooze_cnt, 0);
    trigger();
    press_snooze();
    ticks(10);
    armed = 1'b0;
    cyc();
    chk("disarm_snz", snooze_active, 0);
    chk("disarm_cnt", snooze_cnt, 0);
    armed = 1'b1;
    cur_minutes = 6'd31;
    cyc();
    adjust_mode = 1'b1;
    cur_minutes = 6'd30;
    cyc(3);
    chk("adjust_block", ringing, 0);
    adjust_mode = 1'b0;
    cyc();
    chk("adjust_release", ringing, 1);
    ticks(1);
    rst = 1'b1;
    cyc();
    chk("rst_mid_ring", ringing, 0);
    chk("rst_mid_led", alarm_led, 0);
    chk("rst_mid_snz", snooze_active, 0);
    chk("rst_mid_cnt", snooze_cnt, 0);
    chk("rst_mid_missed", missed, 0);
    cur_minutes = 6'd31;
    rst = 1'b0;
    trigger();
    chk("auto_pre", ringing, 1);
    ticks(5);
`ifdef ALARM_AUTO_SNOOZE_EN
    chk("auto1_snz", snooze_active, 1);
    chk("auto1_cnt", snooze_cnt, 1);
    chk("auto1_missed", missed, 0);
    ticks(65);
    chk("auto2_snz", snooze_active, 1);
    chk("auto2_cnt", snooze_cnt, 2);
    ticks(65);
    chk("auto3_idle", ringing | snooze_active, 0);
    chk("auto3_missed", missed, 1);
`else
    chk("tmo0_idle", ringing | snooze_active, 0);
    chk("tmo0_missed", missed, 1);
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
  initial begin
    #200000;
    $fatal(1, "FAIL timeout observed=running expected=finished");
  end
endmodule
